// File: rtl/vram_rect_fill_if.sv
// ---------------------------------------------------------------------------
// vram_rect_fill_if
//   Bundles the command handshake and the framebuffer write port of the
//   rectangle fill engine.
//
//   Command channel (issuer -> engine):
//     cmd_valid, cmd_x[3:0], cmd_y[3:0], cmd_w[4:0], cmd_h[4:0],
//     cmd_color[11:0] = {B,G,R};  cmd_ready (engine -> issuer)
//   Write channel (engine -> framebuffer RAM):
//     wr_en, wr_addr[15:0], wr_data[15:0];  wr_ready (RAM -> engine)
//
//   modport slave  : the fill engine
//   modport master : command issuer plus memory side (e.g. a testbench)
// ---------------------------------------------------------------------------
interface vram_rect_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_x;
    logic [3:0]  cmd_y;
    logic [4:0]  cmd_w;
    logic [4:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        wr_en;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_x,
        input  cmd_y,
        input  cmd_w,
        input  cmd_h,
        input  cmd_color,
        output wr_en,
        input  wr_ready,
        output wr_addr,
        output wr_data
    );

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_x,
        output cmd_y,
        output cmd_w,
        output cmd_h,
        output cmd_color,
        input  wr_en,
        output wr_ready,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/vram_rect_fill.sv
// ---------------------------------------------------------------------------
// vram_rect_fill
//   Command-driven fill engine: writes one solid-colour, clipped rectangle
//   into the 16-cell-stride framebuffer that the VGA stage scans out.
//   Cells are written row-major, one word per accepted write cycle.
//
//   Ports:
//     clock  : system clock, all logic on posedge
//     reset  : synchronous, active-high
//     bus    : vram_rect_fill_if.slave (command handshake + write port)
//     busy   : high whenever the engine is not idle
//     done   : one-cycle pulse when a command completes
//
//   Parameters:
//     GRID_W, GRID_H : visible grid size in cells (1..16)
//     BASE_ADDR      : address of cell (0,0); cell (x,y) = BASE + y*16 + x
// ---------------------------------------------------------------------------
module vram_rect_fill #(
    parameter int          GRID_W    = 16,
    parameter int          GRID_H    = 16,
    parameter logic [15:0] BASE_ADDR = 16'h2000
) (
    input  logic            clock,
    input  logic            reset,
    vram_rect_fill_if.slave bus,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] GRID_W6 = 6'(GRID_W);
    localparam logic [5:0] GRID_H6 = 6'(GRID_H);

    // Framebuffer address of a cell; row stride is fixed at 16 words.
    function automatic logic [15:0] cell_addr(input logic [3:0] cx, input logic [3:0] cy);
        cell_addr = BASE_ADDR + {8'h00, cy, cx};
    endfunction

    logic [1:0]  state_r;
    logic        cmd_ready_r;
    logic        wr_en_r;
    logic [15:0] wr_addr_r;
    logic [15:0] wr_data_r;
    logic        busy_r;
    logic        done_r;

    logic [3:0]  x0_r;
    logic [3:0]  cx_r;
    logic [3:0]  cy_r;
    logic [5:0]  x_end_r;
    logic [5:0]  y_end_r;

    logic [5:0]  x_sum_s;
    logic [5:0]  y_sum_s;
    logic [5:0]  x_end_s;
    logic [5:0]  y_end_s;
    logic        empty_s;
    logic        row_last_s;
    logic        cell_last_s;
    logic [3:0]  cx_next_s;
    logic [3:0]  cy_next_s;

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Clip the incoming command against the grid; 6-bit sums cannot wrap.
    always_comb begin
        x_sum_s = {2'b00, bus.cmd_x} + {1'b0, bus.cmd_w};
        y_sum_s = {2'b00, bus.cmd_y} + {1'b0, bus.cmd_h};
        if (x_sum_s > GRID_W6) begin
            x_end_s = GRID_W6;
        end else begin
            x_end_s = x_sum_s;
        end
        if (y_sum_s > GRID_H6) begin
            y_end_s = GRID_H6;
        end else begin
            y_end_s = y_sum_s;
        end
        empty_s = (bus.cmd_w == 5'd0) || (bus.cmd_h == 5'd0) ||
                  ({2'b00, bus.cmd_x} >= GRID_W6) || ({2'b00, bus.cmd_y} >= GRID_H6);
    end

    // Next cell in row-major order; wraps to the left column at the row end.
    always_comb begin
        row_last_s  = (({2'b00, cx_r} + 6'd1) == x_end_r);
        cell_last_s = row_last_s && (({2'b00, cy_r} + 6'd1) == y_end_r);
        if (row_last_s) begin
            cx_next_s = x0_r;
            cy_next_s = cy_r + 4'd1;
        end else begin
            cx_next_s = cx_r + 4'd1;
            cy_next_s = cy_r;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 16'h0000;
            wr_data_r   <= 16'h0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            x0_r        <= 4'd0;
            cx_r        <= 4'd0;
            cy_r        <= 4'd0;
            x_end_r     <= 6'd0;
            y_end_r     <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        // Latch the whole command; later input changes are ignored.
                        x0_r        <= bus.cmd_x;
                        cx_r        <= bus.cmd_x;
                        cy_r        <= bus.cmd_y;
                        x_end_r     <= x_end_s;
                        y_end_r     <= y_end_s;
                        wr_addr_r   <= cell_addr(bus.cmd_x, bus.cmd_y);
                        wr_data_r   <= {4'h0, bus.cmd_color};
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (empty_s) begin
                            state_r <= ST_DONE;
                            wr_en_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FILL;
                            wr_en_r <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                        wr_en_r     <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (bus.wr_ready) begin
                        if (cell_last_s) begin
                            state_r <= ST_DONE;
                            wr_en_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            cx_r      <= cx_next_s;
                            cy_r      <= cy_next_s;
                            wr_addr_r <= cell_addr(cx_next_s, cy_next_s);
                        end
                    end else begin
                        // Stalled: address, data and enable hold.
                        wr_en_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                    wr_en_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_vram_rect_fill
//   Table-driven bench for vram_rect_fill. Expected writes are pushed to a
//   scoreboard queue when a command is issued and popped by a write monitor.
//   Hand-written sequences cover reset mid-fill and back-to-back commands.
// ---------------------------------------------------------------------------
module tb_vram_rect_fill;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic done;

    vram_rect_fill_if bus ();

    vram_rect_fill #(
        .GRID_W    (16),
        .GRID_H    (16),
        .BASE_ADDR (16'h2000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [4:0]  w;
        logic [4:0]  h;
        logic [11:0] color;
        logic [31:0] pat;       // wr_ready for cycle n+1 after handshake is pat[n]
        logic [31:0] pat_len;   // cycles beyond pat_len see wr_ready=1
        logic [31:0] exp_writes;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs [9];
    wr_t  exp_q [$];
    int   checks  = 0;
    int   errors  = 0;
    int   accepts = 0;

    logic        hold_pending = 1'b0;
    logic [15:0] hold_addr    = 16'h0000;
    logic [15:0] hold_data    = 16'h0000;

    // Write monitor: scoreboard compare on each accepted write, stability on stalls.
    always @(negedge clock) begin
        wr_t e;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== hold_addr || bus.wr_data !== hold_data) begin
                    errors++;
                    $display("FAIL stall_hold: got en=%b addr=%h data=%h required en=1 addr=%h data=%h",
                             bus.wr_en, bus.wr_addr, bus.wr_data, hold_addr, hold_data);
                end
            end
            if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
                accepts++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%h data=%h required no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                        errors++;
                        $display("FAIL write_value: got addr=%h data=%h required addr=%h data=%h",
                                 bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                end
            end
            hold_pending = (bus.wr_en === 1'b1) && (bus.wr_ready !== 1'b1);
            hold_addr    = bus.wr_addr;
            hold_data    = bus.wr_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int min16(input int a);
        return (a > 16) ? 16 : a;
    endfunction

    // Reference model: push every clipped cell in row-major order.
    task automatic model_push(input vec_t v);
        int xe;
        int ye;
        wr_t e;
        xe = min16(int'(v.x) + int'(v.w));
        ye = min16(int'(v.y) + int'(v.h));
        for (int yy = int'(v.y); yy < ye; yy++) begin
            for (int xx = int'(v.x); xx < xe; xx++) begin
                e.addr = 16'h2000 + 16'(yy * 16 + xx);
                e.data = {4'h0, v.color};
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic rdy(input vec_t v, input int n);
        if (n - 1 < int'(v.pat_len)) return v.pat[n - 1];
        return 1'b1;
    endfunction

    // Cycle (counted from the handshake) on which done is expected.
    function automatic int done_model(input vec_t v);
        int xe;
        int ye;
        int cells;
        int acc;
        xe = min16(int'(v.x) + int'(v.w));
        ye = min16(int'(v.y) + int'(v.h));
        cells = (xe <= int'(v.x) || ye <= int'(v.y)) ? 0 : (xe - int'(v.x)) * (ye - int'(v.y));
        if (cells == 0) return 1;
        acc = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rdy(v, i + 1)) acc++;
            if (acc == cells) return i + 2;
        end
        return -1;
    endfunction

    // Called at posedge+1; waits (bounded) for cmd_ready.
    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got cmd_ready=%b required 1", tag, bus.cmd_ready);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_x     = v.x;
        bus.cmd_y     = v.y;
        bus.cmd_w     = v.w;
        bus.cmd_h     = v.h;
        bus.cmd_color = v.color;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int n;
        int done_at;
        int exp_done;
        int acc0;
        wait_ready(tag);
        drive_cmd(v);
        model_push(v);
        exp_done = done_model(v);
        acc0 = accepts;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 4'($urandom);
        bus.cmd_y     = 4'($urandom);
        bus.cmd_w     = 5'($urandom);
        bus.cmd_h     = 5'($urandom);
        bus.cmd_color = 12'($urandom);
        n = 1;
        done_at = -1;
        bus.wr_ready = rdy(v, 1);
        while (n < 2000) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
            chk({tag, "_busy"}, int'(busy), 1);
            @(posedge clock); #1;
            n++;
            bus.wr_ready = rdy(v, n);
        end
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_writes"}, accepts - acc0, int'(v.exp_writes));
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clock); #1;
        bus.wr_ready = 1'b1;
        chk({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
        chk({tag, "_done_after"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   acc0;
        int   k;

        //            x      y      w       h       color     pat             len    writes
        vecs[0] = '{4'd0,  4'd0,  5'd16, 5'd16, 12'hF00, 32'h0,          32'd0,  32'd256};
        vecs[1] = '{4'd14, 4'd15, 5'd5,  5'd3,  12'h0A5, 32'h0,          32'd0,  32'd2};
        vecs[2] = '{4'd0,  4'd0,  5'd0,  5'd4,  12'h111, 32'h0,          32'd0,  32'd0};
        vecs[3] = '{4'd3,  4'd2,  5'd2,  5'd2,  12'h7C3, 32'b1011001,    32'd7,  32'd4};
        vecs[4] = '{4'd5,  4'd5,  5'd3,  5'd2,  12'h123, 32'h0,          32'd0,  32'd6};
        vecs[5] = '{4'd15, 4'd15, 5'd16, 5'd16, 12'hFFF, 32'h0,          32'd0,  32'd1};
        vecs[6] = '{4'd0,  4'd7,  5'd16, 5'd1,  12'hABC, 32'h0,          32'd0,  32'd16};
        vecs[7] = '{4'd2,  4'd3,  5'd4,  5'd0,  12'h456, 32'h0,          32'd0,  32'd0};
        vecs[8] = '{4'd8,  4'd0,  5'd1,  5'd16, 12'h9E2, 32'hA5A50F0F,   32'd32, 32'd16};

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 4'd0;
        bus.cmd_y     = 4'd0;
        bus.cmd_w     = 5'd0;
        bus.cmd_h     = 5'd0;
        bus.cmd_color = 12'h000;
        bus.wr_ready  = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a 16x1 fill after five accepted writes.
        v = '{4'd0, 4'd3, 5'd16, 5'd1, 12'h7E1, 32'h0, 32'd0, 32'd5};
        wait_ready("rstmid");
        drive_cmd(v);
        model_push(v);
        acc0 = accepts;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        k = 0;
        while (accepts < acc0 + 5 && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        chk("rstmid_accepts", accepts - acc0, 5);
        reset = 1'b1;
        bus.wr_ready = 1'b0;
        @(posedge clock); #1;
        chk("rstmid_wr_en", int'(bus.wr_en), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_wr_addr", int'(bus.wr_addr), 0);
        chk("rstmid_cmd_ready", int'(bus.cmd_ready), 0);
        exp_q.delete();
        reset = 1'b0;
        bus.wr_ready = 1'b1;
        @(posedge clock); #1;
        chk("rstmid_no_done", int'(done), 0);
        v = '{4'd0, 4'd0, 5'd1, 5'd1, 12'h5D0, 32'h0, 32'd0, 32'd1};
        run_cmd(v, "post_rst");

        // Back-to-back: second command held valid while the first runs.
        wait_ready("b2b");
        v = '{4'd1, 4'd1, 5'd1, 5'd1, 12'h3C7, 32'h0, 32'd0, 32'd1};
        drive_cmd(v);
        exp_q.push_back({16'h2011, 16'h03C7});
        acc0 = accepts;
        @(posedge clock); #1;
        v = '{4'd2, 4'd2, 5'd1, 5'd1, 12'h5A5, 32'h0, 32'd0, 32'd1};
        drive_cmd(v);
        exp_q.push_back({16'h2022, 16'h05A5});
        @(negedge clock);
        chk("b2b_c1_ready", int'(bus.cmd_ready), 0);
        chk("b2b_c1_wr_en", int'(bus.wr_en), 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_c2_done", int'(done), 1);
        chk("b2b_c2_ready", int'(bus.cmd_ready), 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_c3_ready", int'(bus.cmd_ready), 1);
        chk("b2b_c3_done", int'(done), 0);
        chk("b2b_c3_busy", int'(busy), 0);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        chk("b2b_c4_wr_en", int'(bus.wr_en), 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_c5_done", int'(done), 1);
        @(posedge clock); #1;
        chk("b2b_writes", accepts - acc0, 2);
        chk("b2b_queue_left", exp_q.size(), 0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
